// File: rtl/hash_core_scheduler.sv
// Hash core scheduler: hands out consecutive candidate indices to a pool of
// hash cores round-robin, collects their results round-robin, remembers the
// first match and signals job completion once every issued candidate is back.
module hash_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 32
) (
  input  logic                         fpgaclk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [IDX_W-1:0]             base_idx,
  input  logic [IDX_W-1:0]             count,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [IDX_W-1:0]             found_idx,
  output logic [NUM_CORES-1:0]         core_valid,
  input  logic [NUM_CORES-1:0]         core_ready,
  output logic [IDX_W-1:0]             core_idx,
  input  logic [NUM_CORES-1:0]         res_valid,
  input  logic [NUM_CORES-1:0]         res_match,
  input  logic [NUM_CORES*IDX_W-1:0]   res_idx,
  output logic [NUM_CORES-1:0]         res_ready
);

  localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  next_q;
  logic [IDX_W-1:0]  remaining_q;
  logic [IDX_W:0]    outst_q, outst_d;
  logic [RR_W-1:0]   rr_disp_q, rr_res_q;
  logic              busy_q, done_q, found_q, found_d;
  logic [IDX_W-1:0]  found_idx_q, found_idx_d;

  logic              disp_en, res_en, res_pending;
  logic [RR_W-1:0]   disp_gnt, res_gnt;
  logic [IDX_W-1:0]  res_sel_idx;

  // First requester at or after ptr, wrapping modulo NUM_CORES.
  function automatic logic [RR_W-1:0] rr_index(input logic [NUM_CORES-1:0] req,
                                               input logic [RR_W-1:0] ptr);
    logic [RR_W-1:0] sel;
    int j;
    sel = ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_CORES;
      if (req[j]) sel = RR_W'(j);
    end
    return sel;
  endfunction

  function automatic logic [NUM_CORES-1:0] to_onehot(input logic [RR_W-1:0] k);
    logic [NUM_CORES-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [RR_W-1:0] inc_mod(input logic [RR_W-1:0] k);
    return (int'(k) == NUM_CORES - 1) ? '0 : k + RR_W'(1);
  endfunction

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign found_idx = found_idx_q;
  assign core_idx  = next_q;

  // Dispatch/result arbitration and next values of the job bookkeeping.
  always_comb begin
    disp_en     = (state_q == DISPATCH) && (remaining_q != '0) && (core_ready != '0);
    disp_gnt    = rr_index(core_ready, rr_disp_q);
    core_valid  = disp_en ? to_onehot(disp_gnt) : '0;
    res_en      = (state_q != IDLE) && (res_valid != '0);
    res_gnt     = rr_index(res_valid, rr_res_q);
    res_ready   = res_en ? to_onehot(res_gnt) : '0;
    res_sel_idx = res_idx[int'(res_gnt)*IDX_W +: IDX_W];
    res_pending = (res_valid & ~res_ready) != '0;

    // A result with nothing outstanding is absorbed without underflowing.
    outst_d = outst_q;
    if (disp_en && !res_en)
      outst_d = outst_q + (IDX_W+1)'(1);
    else if (!disp_en && res_en && (outst_q != '0))
      outst_d = outst_q - (IDX_W+1)'(1);

    // Only the first match of a job is kept.
    found_d     = found_q;
    found_idx_d = found_idx_q;
    if (res_en && !found_q && res_match[res_gnt]) begin
      found_d     = 1'b1;
      found_idx_d = res_sel_idx;
    end
  end

  // Job control FSM with registered busy/done/found outputs.
  always_ff @(posedge fpgaclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      next_q      <= '0;
      remaining_q <= '0;
      outst_q     <= '0;
      rr_disp_q   <= '0;
      rr_res_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
    end else begin
      done_q      <= 1'b0;
      outst_q     <= outst_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
      if (res_en) rr_res_q <= inc_mod(res_gnt);
      if (disp_en) begin
        next_q      <= next_q + IDX_W'(1);
        remaining_q <= remaining_q - IDX_W'(1);
        rr_disp_q   <= inc_mod(disp_gnt);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            next_q      <= base_idx;
            remaining_q <= count;
            found_q     <= 1'b0;
            found_idx_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= (count != '0) ? DISPATCH : FINISH;
          end
        end
        DISPATCH: begin
          // Stop issuing once the last candidate left, a match came back or abort.
          if ((disp_en && (remaining_q == IDX_W'(1))) || (remaining_q == '0) ||
              found_d || abort)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if ((outst_d == '0) && !res_pending)
            state_q <= FINISH;
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_core_scheduler.sv
// Bench for hash_core_scheduler: a behavioural core pool echoes every
// dispatched candidate after a per-core latency; expected dispatches are
// queued per job and checked as the scheduler issues them.
module tb_hash_core_scheduler;
  localparam int NC = 4;
  localparam int W  = 32;

  logic            fpgaclk = 1'b0;
  logic            reset, start, abort;
  logic [W-1:0]    base_idx, count;
  logic            busy, done, found;
  logic [W-1:0]    found_idx, core_idx;
  logic [NC-1:0]   core_valid, core_ready, res_valid, res_match, res_ready;
  logic [NC*W-1:0] res_idx;

  hash_core_scheduler #(.NUM_CORES(NC), .IDX_W(W)) dut (
    .fpgaclk(fpgaclk), .reset(reset), .start(start), .abort(abort),
    .base_idx(base_idx), .count(count), .busy(busy), .done(done),
    .found(found), .found_idx(found_idx), .core_valid(core_valid),
    .core_ready(core_ready), .core_idx(core_idx), .res_valid(res_valid),
    .res_match(res_match), .res_idx(res_idx), .res_ready(res_ready)
  );

  always #5 fpgaclk = ~fpgaclk;

  typedef struct {int core; logic [W-1:0] idx; int due;} res_t;
  typedef struct {int core; logic [W-1:0] idx;} disp_t;

  res_t   pend[$];
  disp_t  exp_disp[$];
  int     lat[NC];
  bit     acc_flag[NC];
  bit     match_en;
  logic [W-1:0] m1, m2;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  int n_disp, n_acc, n_done, first_disp_cyc, last_acc_cyc, done_cyc, job_start_cyc;
  int m_rr_disp = 0, m_rr_res = 0;
  bit saw_all_with_disp;

  int            obs_g, obs_eg;
  disp_t         obs_e;
  res_t          obs_r;
  logic [NC-1:0] obs_exp;

  // Core pool: retire accepted results, then present each core's oldest due result.
  always @(posedge fpgaclk) begin
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < NC; k++) begin
      if (acc_flag[k]) begin
        for (int i = 0; i < pend.size(); i++) begin
          if (pend[i].core == k) begin
            pend.delete(i);
            break;
          end
        end
        acc_flag[k] = 1'b0;
      end
    end
    res_valid = '0;
    res_match = '0;
    res_idx   = '0;
    for (int k = 0; k < NC; k++) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].core == k) begin
          if (pend[i].due <= cyc) begin
            res_valid[k]        = 1'b1;
            res_idx[k*W +: W]   = pend[i].idx;
            res_match[k]        = match_en && (pend[i].idx == m1 || pend[i].idx == m2);
          end
          break;
        end
      end
    end
  end

  // Observe the transfers that the coming rising edge will perform.
  always @(negedge fpgaclk) begin
    if (!reset) begin
      if (core_valid != '0) begin
        obs_g = 0;
        for (int k = 0; k < NC; k++) if (core_valid[k]) obs_g = k;
        n_checks++;
        if (!$onehot(core_valid) || ((core_valid & ~core_ready) != '0)) begin
          n_fail++;
          $display("FAIL disp_onehot: core_valid=%b core_ready=%b", core_valid, core_ready);
        end
        n_checks++;
        if (exp_disp.size() == 0) begin
          n_fail++;
          $display("FAIL disp_unexpected: core_valid=%b idx=%h, expected no dispatch", core_valid, core_idx);
        end else begin
          obs_e = exp_disp.pop_front();
          obs_exp = '0;
          obs_exp[obs_e.core] = 1'b1;
          if (core_valid !== obs_exp || core_idx !== obs_e.idx) begin
            n_fail++;
            $display("FAIL disp_seq: got core_valid=%b idx=%h, expected core_valid=%b idx=%h",
                     core_valid, core_idx, obs_exp, obs_e.idx);
          end
        end
        obs_r.core = obs_g;
        obs_r.idx  = core_idx;
        obs_r.due  = cyc + 1 + lat[obs_g];
        pend.push_back(obs_r);
        m_rr_disp = (obs_g + 1) % NC;
        n_disp++;
        if (first_disp_cyc < 0) first_disp_cyc = cyc;
      end
      if (res_valid != '0) begin
        if (res_valid == '1 && core_valid != '0) saw_all_with_disp = 1'b1;
        obs_eg = m_rr_res;
        for (int i = NC - 1; i >= 0; i--)
          if (res_valid[(m_rr_res + i) % NC]) obs_eg = (m_rr_res + i) % NC;
        obs_exp = '0;
        obs_exp[obs_eg] = 1'b1;
        n_checks++;
        if (res_ready !== obs_exp) begin
          n_fail++;
          $display("FAIL res_rr: res_valid=%b res_ready=%b, expected res_ready=%b", res_valid, res_ready, obs_exp);
        end
        if (res_ready != '0) begin
          for (int k = 0; k < NC; k++) if (res_ready[k]) obs_g = k;
          acc_flag[obs_g] = 1'b1;
          m_rr_res = (obs_g + 1) % NC;
          n_acc++;
          last_acc_cyc = cyc;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL done_busy: busy=%b with done, expected 0", busy);
        end
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge fpgaclk);
    #1;
  endtask

  task automatic push_exp(input int n, input logic [W-1:0] b, input int cfix);
    disp_t e;
    for (int i = 0; i < n; i++) begin
      e.core = (cfix >= 0) ? cfix : (m_rr_disp + i) % NC;
      e.idx  = b + W'(i);
      exp_disp.push_back(e);
    end
  endtask

  task automatic start_job(input logic [W-1:0] b, input logic [W-1:0] c);
    @(posedge fpgaclk);
    #1;
    base_idx = b;
    count    = c;
    start    = 1'b1;
    job_start_cyc = cyc;
    n_disp = 0; n_acc = 0; n_done = 0;
    first_disp_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    saw_all_with_disp = 1'b0;
    @(posedge fpgaclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int t;
    t = 0;
    while (n_done == 0 && t < maxc) begin
      clk_wait(1);
      t++;
    end
    if (n_done == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, maxc);
    end
    clk_wait(3);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || found_idx !== '0 ||
        core_valid !== '0 || res_ready !== '0) begin
      n_fail++;
      $display("FAIL %s: busy=%b done=%b found=%b found_idx=%h core_valid=%b res_ready=%b, expected all zero",
               name, busy, done, found, found_idx, core_valid, res_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_idx = '0; count = '0; core_ready = '0;
    match_en = 1'b0; m1 = '0; m2 = '0;
    foreach (lat[k]) lat[k] = 3;
    clk_wait(3);
    check_outputs_zero("reset_state");
    reset = 1'b0;
    clk_wait(2);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    foreach (lat[k]) lat[k] = 3;
    core_ready = '1;
    match_en = 1'b0;
    push_exp(8, 32'h100, -1);
    start_job(32'h100, 8);
    check_int("basic_busy", int'(busy), 1);
    wait_done(100, "basic");
    check_int("basic_ndisp", n_disp, 8);
    check_int("basic_nacc", n_acc, 8);
    check_int("basic_ndone", n_done, 1);
    check_int("basic_found", int'(found), 0);
    check_int("basic_first_disp", first_disp_cyc, job_start_cyc + 1);
    check_int("basic_done_lat", done_cyc, last_acc_cyc + 2);
    exp_disp.delete();
  endtask

  task automatic test_wrap();
    core_ready = '1;
    push_exp(4, 32'hFFFF_FFFE, -1);
    start_job(32'hFFFF_FFFE, 4);
    wait_done(100, "wrap");
    check_int("wrap_ndisp", n_disp, 4);
    check_int("wrap_ndone", n_done, 1);
    exp_disp.delete();
  endtask

  task automatic test_count_zero();
    core_ready = '1;
    abort = 1'b1;
    n_done = 0;
    clk_wait(3);
    abort = 1'b0;
    check_int("idle_abort_busy", int'(busy), 0);
    check_int("idle_abort_done", n_done, 0);
    start_job(32'h55, 0);
    check_int("zero_busy_c1", int'(busy), 1);
    check_int("zero_done_c1", int'(done), 0);
    clk_wait(1);
    check_int("zero_busy_c2", int'(busy), 0);
    check_int("zero_done_c2", int'(done), 1);
    clk_wait(2);
    check_int("zero_ndisp", n_disp, 0);
    check_int("zero_ndone", n_done, 1);
  endtask

  task automatic test_rr_abort();
    for (int k = 0; k < NC; k++) lat[k] = 3 - k;
    core_ready = '1;
    push_exp(10, 32'h200, -1);
    start_job(32'h200, 100);
    clk_wait(4);
    abort = 1'b1;
    clk_wait(1);
    abort = 1'b0;
    wait_done(100, "abort");
    check_int("abort_ndisp", n_disp, 5);
    check_int("abort_nacc", n_acc, 5);
    check_int("abort_ndone", n_done, 1);
    check_int("abort_all_valid", int'(saw_all_with_disp), 1);
    check_int("abort_pend", pend.size(), 0);
    exp_disp.delete();
  endtask

  task automatic test_match();
    foreach (lat[k]) lat[k] = 3;
    core_ready = 4'b0100;
    match_en = 1'b1;
    m1 = 32'h15;
    m2 = 32'h17;
    push_exp(20, 32'h10, 2);
    start_job(32'h10, 20);
    wait_done(100, "match");
    check_int("match_found", int'(found), 1);
    n_checks++;
    if (found_idx !== 32'h15) begin
      n_fail++;
      $display("FAIL match_found_idx: got %h, expected %h", found_idx, 32'h15);
    end
    check_int("match_ndisp", n_disp, 10);
    check_int("match_nacc", n_acc, 10);
    check_int("match_ndone", n_done, 1);
    check_int("match_pend", pend.size(), 0);
    check_int("match_done_lat", done_cyc, last_acc_cyc + 2);
    clk_wait(5);
    check_int("match_found_hold", int'(found), 1);
    match_en = 1'b0;
    exp_disp.delete();
  endtask

  task automatic test_reset_drain();
    foreach (lat[k]) lat[k] = 20;
    core_ready = '1;
    push_exp(3, 32'h300, -1);
    start_job(32'h300, 3);
    check_int("rst_found_cleared", int'(found), 0);
    clk_wait(4);
    check_int("rst_ndisp_before", n_disp, 3);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("rst_async_zero");
    pend.delete();
    exp_disp.delete();
    foreach (acc_flag[k]) acc_flag[k] = 1'b0;
    m_rr_disp = 0;
    m_rr_res = 0;
    clk_wait(2);
    reset = 1'b0;
    n_done = 0;
    clk_wait(30);
    check_int("rst_no_done", n_done, 0);
    check_int("rst_idle_busy", int'(busy), 0);
    foreach (lat[k]) lat[k] = 2;
    push_exp(4, 32'h400, -1);
    start_job(32'h400, 4);
    wait_done(100, "after_rst");
    check_int("after_rst_ndisp", n_disp, 4);
    check_int("after_rst_nacc", n_acc, 4);
    check_int("after_rst_ndone", n_done, 1);
    exp_disp.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_count_zero();
    test_rr_abort();
    test_match();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hash_core_scheduler.md
HASH_CORE_SCHEDULER -- requirements
Module: hash_core_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of hash cores served (2..16).
REQ-002 SHALL have parameter IDX_W, default 32, candidate index width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports named fpgaclk and reset.
REQ-004 fpgaclk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a search job.
REQ-007 abort  in  1  stop dispatching and drain outstanding work.
REQ-008 base_idx  in  IDX_W  first candidate index of the job.
REQ-009 count  in  IDX_W  number of candidates in the job.
REQ-010 busy  out  1  high from start acceptance until done.
REQ-011 done  out  1  single-cycle job-complete pulse.
REQ-012 found  out  1  a match was reported in the current or last job.
REQ-013 found_idx  out  IDX_W  index of the matching candidate.
REQ-014 core_valid  out  NUM_CORES  one-hot dispatch strobe, per core.
REQ-015 core_ready  in  NUM_CORES  core can accept a candidate.
REQ-016 core_idx  out  IDX_W  candidate index, shared by all cores.
REQ-017 res_valid  in  NUM_CORES  core has a result.
REQ-018 res_match  in  NUM_CORES  result hash equals goal.
REQ-019 res_idx  in  NUM_CORES*IDX_W  result index; core k in bits [k*IDX_W +: IDX_W].
REQ-020 res_ready  out  NUM_CORES  one-hot result acceptance.

Function
REQ-021 SHALL implement states IDLE, DISPATCH, DRAIN, FINISH.
REQ-022 IDLE: on start, latch next=base_idx and remaining=count, clear found and found_idx, and go to DISPATCH (count!=0) or FINISH (count==0).
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 DISPATCH: at most one transfer per cycle, to the first core with core_ready=1, searching from rr_disp upward modulo NUM_CORES.
- core_valid SHALL be combinational on core_ready and contain that single bit.
- core_idx=next.
REQ-025 A transfer SHALL increment next (wrapping modulo 2^IDX_W), decrement remaining, increment outstanding, and set rr_disp to (granted+1) mod NUM_CORES.
REQ-026 core_valid SHALL be all zero in IDLE, DRAIN and FINISH, and also when remaining==0.
REQ-027 Results SHALL be accepted in every state except IDLE, at most one per cycle.
- Selection is round-robin from rr_res among res_valid bits.
- res_ready is one-hot and combinational; acceptance decrements outstanding and sets rr_res to granted+1.
REQ-028 A dispatch and a result acceptance in the same cycle SHALL leave outstanding unchanged.
REQ-029 The first accepted result with res_match=1 SHALL set found=1 and latch found_idx. Later matches SHALL be ignored.
REQ-030 DISPATCH SHALL go to DRAIN when remaining reaches 0, found is set, or abort=1, evaluated after the current cycle's transfer.
REQ-031 DRAIN SHALL go to FINISH in the cycle after outstanding==0 with no valid result pending.
REQ-032 FINISH SHALL assert done for exactly one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-033 found and found_idx SHALL hold until the next accepted start.
REQ-034 Latency: first core_valid is no earlier than the cycle after start; done is asserted 2 cycles after the final result acceptance.
REQ-035 outstanding SHALL be IDX_W+1 bits wide and SHALL never underflow; a result arriving with outstanding==0 is accepted and counted as 0.
REQ-036 abort in IDLE SHALL have no effect.

Reset
REQ-037 Reset SHALL force IDLE, busy=0, done=0, found=0, found_idx=0, core_valid=0, res_ready=0, rr_disp=0, rr_res=0, outstanding=0 and remaining=0, immediately and asynchronously.
REQ-038 Reset mid-job SHALL discard all job state; no done pulse SHALL follow.

Verification
REQ-039 base=0x100, count=8, 4 always-ready cores echoing results a fixed 3 cycles later, no match -> indices 0x100..0x107 issued to cores 0,1,2,3,0,1,2,3; one done pulse; found=0.
REQ-040 base=0x10, count=20, core 2 matches index 0x15 -> found=1, found_idx=0x15; dispatch stops after the match is accepted; done fires only after all outstanding results return.
REQ-041 base=0xFFFFFFFE, count=4 -> core_idx sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-042 count=0 -> busy for 1 cycle, done 2 cycles after start, no core_valid.
REQ-043 All res_valid high simultaneously, with a dispatch in the same cycle -> exactly one res_ready per cycle, rotating; outstanding stays consistent; abort after 5 dispatches -> exactly 5 results drained, then done.
REQ-044 Reset asserted during DRAIN with 3 results outstanding -> all outputs zero at once; no done; a new start then works normally.
